// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Time-slots the shared system RAM between video fetch, the 6502 and the
//   SD-card DMA engine. One access slot is offered per clk_en strobe; slots
//   alternate between a video phase (0) and a processor phase (1).
//
// Ports
//   clk, RESET                 clock and asynchronous active-high reset
//   clk_en                     RAM slot strobe, one slot per high cycle
//   vid_req/vid_addr           video fetch request (read only)
//   vid_ack/vid_rdata          completion pulse and held read data
//   cpu_req/we/addr/wdata      processor request group
//   cpu_ack/cpu_rdata          completion pulse and held read data
//   dma_req/we/addr/wdata      DMA request group
//   dma_ack/dma_rdata          completion pulse and held read data
//   mem_en/we/addr/wdata       RAM command for the current slot
//   mem_rdata                  RAM read data, valid the clk after mem_en
//   owner                      current grant: 0 idle, 1 video, 2 cpu, 3 dma
module ram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 15
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          clk_en,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [7:0]    dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  logic       phase_reg;
  logic       cpu_pending_reg;
  logic       dma_pending_reg;
  logic [3:0] starve_reg;
  owner_t     s1_owner_reg;   // grant of the previous clk; RAM data arrives now
  logic       s1_read_reg;

  owner_t     grant;
  logic       cpu_eligible;
  logic       dma_eligible;
  logic       starved;

  // A pending requester is not offered a slot again until its ack has fired,
  // so a level request held across the ack is not granted twice.
  assign cpu_eligible = cpu_req & ~cpu_pending_reg;
  assign dma_eligible = dma_req & ~dma_pending_reg;
  assign starved      = (starve_reg >= 4'(STARVE_LIMIT));

  always_comb begin
    grant = OWN_IDLE;
    if (clk_en && !RESET) begin
      if (!phase_reg) begin
        if (vid_req)           grant = OWN_VID;
        else if (dma_eligible) grant = OWN_DMA;
      end else begin
        if (dma_eligible && starved) grant = OWN_DMA;
        else if (cpu_eligible)       grant = OWN_CPU;
        else if (dma_eligible)       grant = OWN_DMA;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    case (grant)
      OWN_VID: mem_addr = vid_addr;
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        mem_addr  = dma_addr;
        mem_we    = dma_we;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign mem_en = (grant != OWN_IDLE);
  assign owner  = grant;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      phase_reg       <= 1'b0;
      cpu_pending_reg <= 1'b0;
      dma_pending_reg <= 1'b0;
      starve_reg      <= 4'd0;
      s1_owner_reg    <= OWN_IDLE;
      s1_read_reg     <= 1'b0;
      vid_ack         <= 1'b0;
      cpu_ack         <= 1'b0;
      dma_ack         <= 1'b0;
      vid_rdata       <= 8'd0;
      cpu_rdata       <= 8'd0;
      dma_rdata       <= 8'd0;
    end else begin
      if (clk_en) phase_reg <= ~phase_reg;

      // Stage 1: remember who owns the access whose data arrives next clk.
      // Reloaded every clk so back-to-back grants are tracked independently.
      s1_owner_reg <= grant;
      s1_read_reg  <= (grant != OWN_IDLE) && !mem_we;

      // Stage 2: capture read data and pulse the owner's ack together.
      vid_ack <= (s1_owner_reg == OWN_VID);
      cpu_ack <= (s1_owner_reg == OWN_CPU);
      dma_ack <= (s1_owner_reg == OWN_DMA);
      if (s1_read_reg) begin
        case (s1_owner_reg)
          OWN_VID: vid_rdata <= mem_rdata;
          OWN_CPU: cpu_rdata <= mem_rdata;
          OWN_DMA: dma_rdata <= mem_rdata;
          default: ;
        endcase
      end

      if (grant == OWN_CPU) cpu_pending_reg <= 1'b1;
      else if (cpu_ack)     cpu_pending_reg <= 1'b0;
      if (grant == OWN_DMA) dma_pending_reg <= 1'b1;
      else if (dma_ack)     dma_pending_reg <= 1'b0;

      // Counts processor-phase slots the DMA engine loses while requesting.
      if (!dma_req || grant == OWN_DMA) starve_reg <= 4'd0;
      else if (clk_en && phase_reg && starve_reg != 4'd15)
        starve_reg <= starve_reg + 4'd1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a registered RAM behind it and a
//   transaction-level reference model checked on every falling edge.
module tb_ram_arbiter;
  localparam int AW = 15;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          clk_en = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [7:0]    vid_rdata;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = 8'd0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_wdata = 8'd0;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'd0;
  logic [1:0]    owner;

  ram_arbiter #(.STARVE_LIMIT(SL), .AW(AW)) dut (
    .clk(clk), .RESET(RESET), .clk_en(clk_en),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit en_run   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered RAM behind the arbiter, content ram[a] = a[7:0] ^ a[14:8].
  logic [7:0] tb_ram [0:(1<<AW)-1];
  logic [7:0] mram   [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      tb_ram[i] = 8'(i) ^ 8'(i >> 8);
      mram[i]   = 8'(i) ^ 8'(i >> 8);
    end
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_ram[mem_addr] <= mem_wdata;
      mem_rdata <= tb_ram[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         who;
    bit         rd;
    logic [7:0] data;
  } tx_t;
  tx_t        q[$];
  int         cyc = 0;
  bit         m_phase = 0;
  bit         m_pend [1:3];
  int         m_starve = 0;
  logic [7:0] m_rdata [1:3];
  logic [AW-1:0] cap_waddr = '0;

  initial begin
    for (int w = 1; w <= 3; w++) begin
      m_pend[w]  = 0;
      m_rdata[w] = 8'd0;
    end
  end

  always @(negedge clk) begin
    int g;
    bit e_ack [1:3];
    bit cpu_ok, dma_ok;
    logic [AW-1:0] e_addr;
    bit e_we;
    logic [7:0] e_wd;
    tx_t t;
    cyc++;
    for (int w = 1; w <= 3; w++) e_ack[w] = 0;
    g = 0; e_addr = '0; e_we = 0; e_wd = 8'd0;
    if (owner == 2'd2 && mem_we) cap_waddr = mem_addr;
    if (RESET) begin
      q.delete();
      m_phase = 0; m_starve = 0;
      for (int w = 1; w <= 3; w++) begin
        m_pend[w] = 0; m_rdata[w] = 8'd0;
      end
    end else begin
      while (q.size() > 0 && q[0].due == cyc) begin
        e_ack[q[0].who] = 1;
        if (q[0].rd) m_rdata[q[0].who] = q[0].data;
        void'(q.pop_front());
      end
      if (clk_en) begin
        cpu_ok = cpu_req && !m_pend[2];
        dma_ok = dma_req && !m_pend[3];
        if (!m_phase) g = vid_req ? 1 : (dma_ok ? 3 : 0);
        else g = (dma_ok && m_starve >= SL) ? 3 : (cpu_ok ? 2 : (dma_ok ? 3 : 0));
      end
      case (g)
        1: e_addr = vid_addr;
        2: begin e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata; end
        3: begin e_addr = dma_addr; e_we = dma_we; e_wd = dma_wdata; end
        default: ;
      endcase
    end

    chk("m_mem_en", {31'd0, mem_en}, {31'd0, g != 0});
    chk("m_owner", {30'd0, owner}, 32'(g));
    chk("m_vid_ack", {31'd0, vid_ack}, {31'd0, e_ack[1]});
    chk("m_cpu_ack", {31'd0, cpu_ack}, {31'd0, e_ack[2]});
    chk("m_dma_ack", {31'd0, dma_ack}, {31'd0, e_ack[3]});
    chk("m_vid_rdata", {24'd0, vid_rdata}, {24'd0, m_rdata[1]});
    chk("m_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, m_rdata[2]});
    chk("m_dma_rdata", {24'd0, dma_rdata}, {24'd0, m_rdata[3]});
    if (g != 0) begin
      chk("m_mem_addr", {17'd0, mem_addr}, {17'd0, e_addr});
      chk("m_mem_we", {31'd0, mem_we}, {31'd0, e_we});
      if (e_we) chk("m_mem_wdata", {24'd0, mem_wdata}, {24'd0, e_wd});
    end

    if (!RESET) begin
      for (int w = 2; w <= 3; w++) if (e_ack[w]) m_pend[w] = 0;
      if (g != 0) begin
        if (g >= 2) m_pend[g] = 1;
        t.due = cyc + 2; t.who = g; t.rd = !e_we; t.data = mram[e_addr];
        q.push_back(t);
        if (e_we) mram[e_addr] = e_wd;
      end
      if (!dma_req || g == 3) m_starve = 0;
      else if (clk_en && m_phase && m_starve < 15) m_starve++;
      if (clk_en) m_phase = !m_phase;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    clk_en = en_run ? ~clk_en : 1'b0;
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      1: return vid_ack;
      2: return cpu_ack;
      default: return dma_ack;
    endcase
  endfunction

  task automatic wait_ack(input int who, input int maxc, output int waited);
    waited = -1;
    for (int i = 1; i <= maxc; i++) begin
      cycle();
      if (ack_of(who)) begin
        waited = i;
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL ack_timeout: requester %0d got no ack, required within %0d clks", who, maxc);
  endtask

  initial begin
    int w, w2, cpu_n;
    bit seen;
    // Reset with video and cpu already requesting.
    vid_req = 1; vid_addr = 15'h1234;
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010;
    repeat (3) cycle();
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    RESET = 0;
    en_run = 1;

    // 1: first slot is video, then cpu.
    wait_ack(1, 6, w);
    chk("vid_latency", 32'(w), 32'd3);
    chk("vid_rdata_1234", {24'd0, vid_rdata}, 32'h26);
    wait_ack(2, 6, w);
    chk("cpu_after_vid", 32'(w), 32'd2);
    chk("cpu_rdata_0010", {24'd0, cpu_rdata}, 32'h10);
    cpu_req = 0;

    // 2: cpu write then read back.
    cpu_we = 1; cpu_addr = 15'h0100; cpu_wdata = 8'hA5; cpu_req = 1;
    wait_ack(2, 10, w);
    cpu_req = 0;
    chk("cpu_wr_addr", {17'd0, cap_waddr}, 32'h0100);
    chk("wr_keeps_rdata", {24'd0, cpu_rdata}, 32'h10);
    cpu_we = 0; cpu_req = 1;
    wait_ack(2, 10, w);
    cpu_req = 0;
    chk("cpu_readback", {24'd0, cpu_rdata}, 32'hA5);

    // 3: blanking, DMA read takes the video phase.
    vid_req = 0;
    dma_we = 0; dma_addr = 15'h2000; dma_req = 1;
    wait_ack(3, 10, w);
    dma_req = 0;
    chk("dma_rdata_2000", {24'd0, dma_rdata}, 32'h20);

    // 5: held DMA request is not re-granted until after its ack.
    dma_addr = 15'h0123; dma_req = 1;
    wait_ack(3, 10, w);
    wait_ack(3, 10, w2);
    dma_req = 0;
    chk("dma_held_spacing", 32'(w2), 32'd4);

    // 4: starvation with video and cpu saturating their phases.
    repeat (4) cycle();
    vid_req = 1; cpu_addr = 15'h0020; cpu_req = 1;
    dma_addr = 15'h0030; dma_req = 1;
    cpu_n = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      if (cpu_ack) cpu_n++;
      if (dma_ack) seen = 1;
    end
    dma_req = 0;
    chk("dma_seen", {31'd0, seen}, 32'd1);
    chk("starve_cpu_wins", 32'(cpu_n), 32'(SL));
    chk("starve_dma_rdata", {24'd0, dma_rdata}, 32'h30);
    wait_ack(2, 10, w);
    chk("cpu_after_dma", 32'(w), 32'd4);
    cpu_req = 0;
    vid_req = 0;
    repeat (4) cycle();

    // 6: reset one clk after a DMA read grant aborts it.
    dma_addr = 15'h2000; dma_req = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (owner == 2'd3) seen = 1;
    end
    chk("abort_grant_seen", {31'd0, seen}, 32'd1);
    cycle();
    RESET = 1; en_run = 0; clk_en = 0; dma_req = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort_no_ack", {31'd0, dma_ack}, 32'd0);
      chk("abort_dma_rdata", {24'd0, dma_rdata}, 32'd0);
      chk("abort_owner", {30'd0, owner}, 32'd0);
    end
    RESET = 0;
    vid_req = 1; cpu_addr = 15'h0010; cpu_req = 1; en_run = 1;
    cycle();
    chk("restart_phase0_video", {30'd0, owner}, 32'd1);
    wait_ack(2, 8, w);
    cpu_req = 0; vid_req = 0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
